// File: rtl/regfile_writeback_pkg.sv
// Shared pipeline constants for the writeback stage and its register file.
package regfile_writeback_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int NUM_REGS       = 32;
  localparam int REG_IDX_W      = 5;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

endpackage : regfile_writeback_pkg

// File: rtl/regfile_readport.sv
// One decode read port: register 0 reads zero, and the writeback value is bypassed
// so a same-cycle read sees the value about to be written.
module regfile_readport
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [REG_IDX_W-1:0] ra,
  input  logic [DATA_W-1:0]    storedData,
  input  logic                 bypassEn,
  input  logic [REG_IDX_W-1:0] bypassReg,
  input  logic [DATA_W-1:0]    bypassData,
  output logic [DATA_W-1:0]    rd
);

  always_comb begin
    rd = storedData;
    if (ra == ZERO_REG) begin
      rd = '0;
    end else if (bypassEn && (bypassReg == ra)) begin
      rd = bypassData;
    end
  end

endmodule : regfile_readport

// File: rtl/regfile_writeback.sv
// Writeback stage: selects the result, commits it to the 32-entry register file
// and counts committed writes; two bypassing read ports serve decode.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regWriteW,
  input  logic                 memToRegW,
  input  logic [DATA_W-1:0]    aluOutW,
  input  logic [DATA_W-1:0]    readDataW,
  input  logic [REG_IDX_W-1:0] writeRegW,
  input  logic [REG_IDX_W-1:0] ra1D,
  input  logic [REG_IDX_W-1:0] ra2D,
  output logic [DATA_W-1:0]    rd1D,
  output logic [DATA_W-1:0]    rd2D,
  output logic [DATA_W-1:0]    resultW,
  output logic [CNT_W-1:0]     wbCount
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [CNT_W-1:0]  r_wbCount;
  logic [DATA_W-1:0] w_result;
  logic              w_commit;

  assign w_result = memToRegW ? readDataW : aluOutW;
  // Writes aimed at register 0 are dropped entirely, including the count.
  assign w_commit = regWriteW && (writeRegW != ZERO_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wbCount <= '0;
    end else if (w_commit) begin
      r_regs[writeRegW] <= w_result;
      r_wbCount         <= r_wbCount + CNT_W'(1);
    end
  end

  regfile_readport #(.DATA_W(DATA_W)) u_readPort1 (
    .ra         (ra1D),
    .storedData (r_regs[ra1D]),
    .bypassEn   (regWriteW),
    .bypassReg  (writeRegW),
    .bypassData (w_result),
    .rd         (rd1D)
  );

  regfile_readport #(.DATA_W(DATA_W)) u_readPort2 (
    .ra         (ra2D),
    .storedData (r_regs[ra2D]),
    .bypassEn   (regWriteW),
    .bypassReg  (writeRegW),
    .bypassData (w_result),
    .rd         (rd2D)
  );

  assign resultW = w_result;
  assign wbCount = r_wbCount;

endmodule : regfile_writeback
